// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } sa_state_t;

    // Default operand width and the matching bit-counter width
    localparam int SA_WIDTH = 8;
    localparam int CNT_W    = $clog2(SA_WIDTH);

    // Counter width for an arbitrary operand width (needs to reach width-1)
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa1_cell.sv
// Single 1-bit full-adder cell; the only arithmetic resource of the serial adder.
module fa1_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum is the parity of the inputs, carry is their majority
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one operand bit per clock through a shared fa1_cell.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' input that turns the op into a-b.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sa_state_t        state;
    sa_state_t        state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] result_sr;
    logic [WIDTH-1:0] result_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             cell_s;
    logic             cell_co;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    fa1_cell u_fa1 (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (cell_s),
        .co (cell_co)
    );

    // Operand conditioning at load time: subtraction is a + ~b + 1
    always_comb begin
        b_load     = b;
        carry_load = cin;
`ifdef SERIAL_ADD_SUB_EN
        if (sub) begin
            b_load     = ~b;
            carry_load = 1'b1;
        end
`endif
    end

    // Handshake decode and the result word as it will look after this cycle's shift
    always_comb begin
        accept      = start && (state != S_RUN);
        last_bit    = (state == S_RUN) && (cnt == CNT_LAST);
        result_next = {cell_s, result_sr[WIDTH-1:1]};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: load on an accepted start, shift one bit per RUN cycle, publish on the last bit
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            result_sr <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
        end else if (accept) begin
            a_sr      <= a;
            b_sr      <= b_load;
            result_sr <= '0;
            carry     <= carry_load;
            cnt       <= '0;
        end else if (state == S_RUN) begin
            a_sr      <= a_sr >> 1;
            b_sr      <= b_sr >> 1;
            result_sr <= result_next;
            carry     <= cell_co;
            cnt       <= cnt + 1'b1;
            if (last_bit) begin
                sum  <= result_next;
                cout <= cell_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl (WIDTH=8); SERIAL_ADD_SUB_EN enables the subtract cases.
module tb_serial_add_ctrl;
    import serial_add_pkg::*;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int compared   = 0;
    int mismatched = 0;

    logic [WIDTH:0] exp_q[$];

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub_in),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expected result
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_done", 32'd1, 32'd0);
            end else begin
                check_output("scoreboard", {23'd0, cout, sum}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    // Drive one start request at a negedge; returns one cycle later with start released
    task automatic apply_stimulus(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                                  input logic tsub, input bit expect_result);
        logic [8:0] model;
        a      = ta;
        b      = tb;
        cin    = tcin;
        sub_in = tsub;
        start  = 1'b1;
        if (tsub) model = {1'b0, ta} + {1'b0, ~tb} + 9'd1;
        else      model = {1'b0, ta} + {1'b0, tb} + {8'd0, tcin};
        if (expect_result) exp_q.push_back(model);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; n counts cycles with the start cycle as cycle 1
    task automatic wait_done(output int n, output int busy_n);
        n      = 2;
        busy_n = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
            n++;
        end
        check_output("done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int n;
        int busy_n;
        int gap;
        int quiet;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic       rs;

        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        sub_in = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_done", {31'd0, done}, 32'd0);
        check_output("rst_sum", {24'd0, sum}, 32'd0);
        check_output("rst_cout", {31'd0, cout}, 32'd0);
        check_output("rst_state", 32'(dut.state), 32'(S_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // 0x0F + 0x01: latency and busy length
        apply_stimulus(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1);
        wait_done(n, busy_n);
        check_output("t1_latency", 32'(n), 32'd10);
        check_output("t1_busy_cycles", 32'(busy_n), 32'd8);
        check_output("t1_sum", {24'd0, sum}, 32'h10);
        check_output("t1_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        check_output("t1_done_one_cycle", {31'd0, done}, 32'd0);
        check_output("t1_idle", 32'(dut.state), 32'(S_IDLE));

        // Wrap and carry-out cases
        apply_stimulus(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        wait_done(n, busy_n);
        check_output("t2a_sum", {24'd0, sum}, 32'h00);
        check_output("t2a_cout", {31'd0, cout}, 32'd1);
        @(negedge clk);
        apply_stimulus(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
        wait_done(n, busy_n);
        check_output("t2b_sum", {24'd0, sum}, 32'hFF);
        check_output("t2b_cout", {31'd0, cout}, 32'd1);
        @(negedge clk);

        // start while busy is ignored
        apply_stimulus(8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        a     = 8'h55;
        b     = 8'hAA;
        cin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, busy_n);
        check_output("t3_sum", {24'd0, sum}, 32'h03);
        check_output("t3_cout", {31'd0, cout}, 32'd0);
        quiet = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) quiet++;
        end
        check_output("t3_single_done", 32'(quiet), 32'd0);

        // Reset in the 4th RUN cycle aborts the op
        apply_stimulus(8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_output("t4_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_output("t4_busy", {31'd0, busy}, 32'd0);
        check_output("t4_done", {31'd0, done}, 32'd0);
        check_output("t4_sum", {24'd0, sum}, 32'd0);
        check_output("t4_cout", {31'd0, cout}, 32'd0);
        check_output("t4_state", 32'(dut.state), 32'(S_IDLE));
        rst   = 1'b0;
        quiet = 0;
        repeat (14) begin
            @(negedge clk);
            if (done === 1'b1) quiet++;
        end
        check_output("t4_no_done", 32'(quiet), 32'd0);

        // Back-to-back: start in the done cycle goes straight to RUN
        apply_stimulus(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
        wait_done(n, busy_n);
        check_output("t5_first_sum", {24'd0, sum}, 32'h02);
        apply_stimulus(8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
        check_output("t5_no_gap_busy", {31'd0, busy}, 32'd1);
        check_output("t5_no_gap_state", 32'(dut.state), 32'(S_RUN));
        wait_done(n, busy_n);
        check_output("t5_sum", {24'd0, sum}, 32'h30);
        check_output("t5_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);

`ifdef SERIAL_ADD_SUB_EN
        // Subtraction: cout=1 means no borrow
        apply_stimulus(8'h05, 8'h07, 1'b0, 1'b1, 1'b1);
        wait_done(n, busy_n);
        check_output("t6a_sum", {24'd0, sum}, 32'hFE);
        check_output("t6a_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        apply_stimulus(8'h07, 8'h05, 1'b1, 1'b1, 1'b1);
        wait_done(n, busy_n);
        check_output("t6b_sum", {24'd0, sum}, 32'h02);
        check_output("t6b_cout", {31'd0, cout}, 32'd1);
        @(negedge clk);
`endif

        // Random ops with random gaps and operand churn while busy
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            apply_stimulus(ra, rb, rc, rs, 1'b1);
            a   = 8'($urandom);
            b   = 8'($urandom);
            cin = 1'($urandom);
            wait_done(n, busy_n);
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
